// File: rtl/smss_gf64_pkg.sv
// ============================================================================
// smss_gf64_pkg : GF(2^6) constants, FSM state type and field multiply.
// Revision      : 1.0
// ============================================================================
`default_nettype none

package smss_gf64_pkg;

  localparam int         W       = 6;
  localparam logic [6:0] POLY    = 7'b1000011;
  localparam int         LATENCY = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Carry-less product, then fold each high bit back using POLY (x^6 = x + 1).
  function automatic logic [W-1:0] gf64_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-2:0] p;
    p = '0;
    for (int i = 0; i < W; i++) begin
      if (b[i]) p = p ^ ({{(W-1){1'b0}}, a} << i);
    end
    for (int k = 2*W-2; k >= W; k--) begin
      if (p[k]) p = p ^ ({{(2*W-1-7){1'b0}}, POLY} << (k-W));
    end
    return p[W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/gf64_mul_comb.sv
// ============================================================================
// gf64_mul_comb : combinational 6x6 GF(2^6) multiply with reduction.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module gf64_mul_comb
  import smss_gf64_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p
);

  assign p = gf64_mul(a, b);

endmodule

`default_nettype wire

// File: rtl/smss_pow17_seq.sv
// ============================================================================
// smss_pow17_seq : sequential x^17 over GF(2^6), four squarings + one multiply.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module smss_pow17_seq
  import smss_gf64_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);

  state_t       state;
  logic [W-1:0] base;
  logic [W-1:0] acc;
  logic [1:0]   cnt;
  logic [W-1:0] op_b;
  logic [W-1:0] prod;

  // One shared multiplier: acc*acc while squaring, acc*base for the final step.
  assign op_b = (state == MUL) ? base : acc;

  gf64_mul_comb u_mul (
    .a (acc),
    .b (op_b),
    .p (prod)
  );

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      base     <= '0;
      acc      <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            base  <= in_data;
            acc   <= in_data;
            cnt   <= '0;
            state <= SQR;
          end
        end
        SQR: begin
          acc <= prod;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= MUL;
        end
        MUL: begin
          out_data <= prod;
          state    <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              base  <= in_data;
              acc   <= in_data;
              cnt   <= '0;
              state <= SQR;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_smss_pow17_seq.sv
// ============================================================================
// tb_smss_pow17_seq : self-checking bench for smss_pow17_seq.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_smss_pow17_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_data;
  logic       busy;

  int total = 0;
  int bad   = 0;

  smss_pow17_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: shift-and-add multiply, power by repeated multiplication.
  function automatic logic [5:0] m_mul(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] r, aa;
    logic       c;
    r  = '0;
    aa = a;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) r = r ^ aa;
      c  = aa[5];
      aa = {aa[4:0], 1'b0};
      if (c) aa = aa ^ 6'b000011;
    end
    return r;
  endfunction

  function automatic logic [5:0] m_pow(input logic [5:0] x, input int n);
    logic [5:0] r;
    r = 6'd1;
    for (int i = 0; i < n; i++) r = m_mul(r, x);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [5:0] x);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = x;
    tick();
    in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_out(output int c);
    c = 0;
    while (!out_valid && c < 20) begin
      tick();
      c++;
    end
  endtask

  task automatic run_one(input string tag, input logic [5:0] x);
    int c;
    accept(x);
    wait_out(c);
    chk({tag, "_latency"}, c, 32'd5);
    chk({tag, "_data"}, {26'd0, out_data}, {26'd0, m_pow(x, 17)});
    out_ready = 1'b1;
    tick();
    chk({tag, "_released"}, {31'd0, out_valid}, 32'd0);
  endtask

  logic [5:0] perm [64];
  logic [5:0] tmp;
  logic [5:0] held;
  int         c;
  int         j;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_out_data",  {26'd0, out_data},  32'd0);
    rst_n = 1'b1;
    tick();

    // Basic values with known answers.
    chk("model_alpha17", {26'd0, m_pow(6'h02, 17)}, 32'h26);
    run_one("basic00", 6'h00);
    chk("basic00_const", {26'd0, out_data}, 32'h00);
    run_one("basic01", 6'h01);
    chk("basic01_const", {26'd0, out_data}, 32'h01);
    run_one("basic02", 6'h02);
    chk("basic02_const", {26'd0, out_data}, 32'h26);

    // Exhaustive, back-to-back, in shuffled order.
    for (int i = 0; i < 64; i++) perm[i] = i[5:0];
    for (int i = 63; i > 0; i--) begin
      j       = $urandom_range(i, 0);
      tmp     = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = perm[0];
    tick();
    for (int i = 0; i < 64; i++) begin
      wait_out(c);
      chk("exh_latency", c, 32'd5);
      chk("exh_inverse", {26'd0, m_pow(out_data, 26)}, {26'd0, perm[i]});
      chk("exh_data", {26'd0, out_data}, {26'd0, m_pow(perm[i], 17)});
      chk("exh_in_ready", {31'd0, in_ready}, 32'd1);
      if (i < 63) in_data = perm[i+1];
      else        in_valid = 1'b0;
      tick();
    end
    chk("exh_drained", {31'd0, out_valid}, 32'd0);
    tick();
    chk("exh_idle", {31'd0, busy}, 32'd0);

    // Backpressure with garbage input pulses while stalled.
    out_ready = 1'b0;
    accept(6'h02);
    wait_out(c);
    chk("bp_latency", c, 32'd5);
    for (int i = 0; i < 10; i++) begin
      in_valid = $urandom_range(1, 0);
      in_data  = $urandom_range(63, 0);
      tick();
      chk("bp_data",      {26'd0, out_data},  32'h26);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_one_transfer", {31'd0, out_valid}, 32'd0);
    repeat (3) tick();
    chk("bp_no_repeat", {31'd0, out_valid | busy}, 32'd0);

    // Random operands with ignored in_valid pulses while busy.
    for (int n = 0; n < 8; n++) begin
      held      = $urandom_range(63, 0);
      out_ready = 1'b0;
      accept(held);
      for (int k = 0; k < 5; k++) begin
        chk("ign_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = $urandom_range(1, 0);
        in_data  = $urandom_range(63, 0);
        tick();
      end
      in_valid = 1'b0;
      chk("ign_valid", {31'd0, out_valid}, 32'd1);
      chk("ign_data", {26'd0, out_data}, {26'd0, m_pow(held, 17)});
      out_ready = 1'b1;
      tick();
    end

    // Asynchronous reset during squaring, cnt == 2.
    out_ready = 1'b1;
    accept(6'h07);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",      {31'd0, busy},      32'd0);
    chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_data",  {26'd0, out_data},  32'd0);
    tick();
    rst_n = 1'b1;
    c = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) c++;
    end
    chk("mid_rst_no_result", c, 32'd0);
    run_one("after_rst03", 6'h03);

    // Simultaneous output transfer and new accept.
    out_ready = 1'b0;
    accept(6'h04);
    wait_out(c);
    chk("sim_first_latency", c, 32'd5);
    chk("sim_first_data", {26'd0, out_data}, {26'd0, m_pow(6'h04, 17)});
    in_valid  = 1'b1;
    in_data   = 6'h05;
    out_ready = 1'b1;
    #1;
    chk("sim_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("sim_transferred", {31'd0, out_valid}, 32'd0);
    chk("sim_accepted",    {31'd0, busy},      32'd1);
    wait_out(c);
    chk("sim_second_latency", c, 32'd5);
    chk("sim_second_data", {26'd0, out_data}, {26'd0, m_pow(6'h05, 17)});
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/smss_pow17_seq.md
# smss_pow17_seq

Sequential GF(2^6) power-17 evaluator: the inverse direction of the SMSS power-26 core, since 26·17 ≡ 1 mod 63. Accepts one 6-bit field element per transaction over a valid/ready handshake. Computes x^17 = (x^16)·x by four squarings and one multiply, one field operation per clock, and presents the result over a valid/ready handshake. It sits on the decrypt/inverse path of the SMSS S-box pipeline, where area matters more than throughput.

## Interface
- POLY, 7'b1000011, reduction polynomial x^6+x+1 (primitive); operands use polynomial basis, bit i = coefficient of α^i.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept in_data this cycle.
- in_data  input  6  operand x.
- out_valid  output  1  out_data holds x^17.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  6  result x^17, registered.
- busy  output  1  high in any state other than IDLE.

## Operation
- Datapath registers:
  - base[5:0]: the latched x.
  - acc[5:0]: the running power.
  - cnt[1:0]: squaring counter.
  - out_data[5:0].
- State machine states: IDLE, SQR, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On the in_valid&in_ready edge: base←in_data, acc←in_data, cnt←0, go to SQR.
- SQR:
  - Each edge: acc←acc² mod POLY, cnt←cnt+1.
  - On the edge where cnt==3, go to MUL instead of staying; acc then equals x^16.
- MUL:
  - One edge: out_data←acc·base mod POLY, go to DONE.
- DONE:
  - out_valid=1; out_data is held stable while out_ready=0.
  - On the out_valid&out_ready edge: go to IDLE.
  - If in_valid is also high on that edge, accept the new operand and go directly to SQR (back-to-back issue).
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational from state and out_ready only, never from in_valid.
- x=0 yields 0 and x=1 yields 1; there are no special cases, since the arithmetic handles both.
- Field arithmetic:
  - Carry-less multiply of two 6-bit values gives an 11-bit product, reduced modulo POLY: bit k≥6 folds into bits k-6 and k-5.
  - Squaring uses the same multiplier with both operands equal, or a dedicated linear squarer; the two must be bit-identical.
- Reset, asserted at any time: state→IDLE; base, acc, cnt and out_data→0. On deassert, outputs read out_valid=0, in_ready=1, busy=0, out_data=0. An in-flight operation is discarded and produces no output.
- in_data is ignored whenever in_ready=0, and out_ready is ignored when out_valid=0.

## Timing
- Latency: the accept edge is edge 0; out_valid rises after edge 5 (4 SQR edges plus 1 MUL edge), so the result is visible 6 cycles after acceptance.
- Throughput: one result per 6 cycles with out_ready held high and in_valid held high.
- Backpressure: DONE persists indefinitely; no new operand is accepted until the output handshake completes.
- in_ready, out_valid and busy are glitch-free decodes of registered state.
- No combinational path exists from in_data to out_data.

## Structure
- Package smss_gf64_pkg holds:
  - POLY.
  - Field width constant W=6.
  - State enum {IDLE,SQR,MUL,DONE}.
  - LATENCY=6.
  - Function gf64_mul(a,b).
- One sub-module, gf64_mul_comb: a combinational 6×6 multiply with reduction, instantiated once and shared between SQR (operands acc,acc) and MUL (operands acc,base) via an operand mux.
- The top level holds the FSM, counter, registers and handshake.

## Test plan
- Basic values:
  - Stimulus: reset, then send 0x00, 0x01 and 0x02 with out_ready=1.
  - Response: outputs 0x00, 0x01, 0x26; each out_valid exactly 6 cycles after its accept.
- Exhaustive inverse check:
  - Stimulus: all 64 inputs, back-to-back with in_valid and out_ready held high.
  - Response: every output y satisfies y^26 == x against the software model; one output per 6 cycles; no drops or duplicates.
- Backpressure:
  - Stimulus: input 0x02; hold out_ready=0 for 10 cycles after out_valid rises.
  - Response: out_data stays 0x26, out_valid stays high and in_ready stays 0 throughout; exactly one transfer when out_ready rises.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously during SQR (cnt=2).
  - Response: all outputs immediately return to reset values; no result emerges; the next operand, 0x03, completes normally with the model-correct value.
- Simultaneous handshake:
  - Stimulus: in DONE, with out_ready=1 and in_valid=1 carrying 0x05.
  - Response: the old result transfers and 0x05 is accepted on the same edge; the next out_valid follows 6 cycles later.
- Ignored input:
  - Stimulus: in_valid pulses with garbage in_data while busy and in_ready=0.
  - Response: no effect on the current result.
